// File: rtl/bcd_serial_addsub_if.sv
// Handshake and operand/result bundle for the digit-serial BCD add/subtract unit.
interface bcd_serial_addsub_if #(
  parameter int unsigned DIGITS = 4
);
  localparam int unsigned W = 4 * DIGITS;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         c_out;
  logic         invalid;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, c_out, invalid
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, c_out, invalid
  );
endinterface

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor, LSD first, one digit per clock.
// Subtraction is A + 9's-complement(B) + 1; c_out reports borrow when subtracting.
module bcd_serial_addsub #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_serial_addsub_if.slave bus
);
  localparam int unsigned W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic               sub_q, sub_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       result_q, result_d;
  logic               c_out_q, c_out_d;
  logic               invalid_q, invalid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [3:0]         a_dig, b_dig, bd, dig;
  logic [4:0]         s, s6;
  logic               carry_nx;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      carry_q   <= 1'b0;
      result_q  <= '0;
      c_out_q   <= 1'b0;
      invalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sub_q     <= sub_d;
      carry_q   <= carry_d;
      result_q  <= result_d;
      c_out_q   <= c_out_d;
      invalid_q <= invalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Digit arithmetic, next-state and output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    sub_d     = sub_q;
    carry_d   = carry_q;
    result_d  = result_q;
    c_out_d   = c_out_q;
    invalid_d = invalid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        a_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
      end
    end

    // Non-BCD digits wrap mod 16 in the 9's complement; no saturation.
    bd       = sub_q ? 4'(4'd9 - b_dig) : b_dig;
    s        = 5'(a_dig) + 5'(bd) + 5'(carry_q);
    s6       = s + 5'd6;
    carry_nx = (s > 5'd9);
    dig      = carry_nx ? s6[3:0] : s[3:0];

    unique case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (bus.start) begin
          state_d   = RUN;
          a_d       = bus.a;
          b_d       = bus.b;
          sub_d     = bus.sub;
          carry_d   = bus.sub;
          cnt_d     = '0;
          result_d  = '0;
          invalid_d = 1'b0;
          busy_d    = 1'b1;
        end
      end
      RUN: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (cnt_q == CNT_W'(i)) result_d[4*i +: 4] = dig;
        end
        if ((a_dig > 4'd9) || (b_dig > 4'd9)) invalid_d = 1'b1;
        carry_d = carry_nx;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIGITS - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          c_out_d = sub_q ? ~carry_nx : carry_nx;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.c_out   = c_out_q;
  assign bus.invalid = invalid_q;
endmodule
